// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline stall/flush control
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Encoding of the mult/div select carried with an MD start
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Default busy durations of the MD unit, in cycles after the start edge
    localparam int MULT_CYCLES_DFLT = 5;
    localparam int DIV_CYCLES_DFLT  = 10;

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: tracks how long the mult/div unit stays busy after a start
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             kill,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic             overlap
);

    md_state_t state;

    // Timer FSM: a start in IDLE loads the op length, BUSY counts down to 1 then returns to IDLE;
    // an in-flight op ignores kill, and a start while busy only raises the sticky overlap flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            overlap <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= (is_div == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end
                end
                BUSY: begin
                    if (start)
                        overlap <= 1'b1;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
    parameter int CNT_W       = 4,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_stall_req,
    input  logic              D_is_md,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic              M_exc_req,
    input  logic              M_eret,
    output logic              FD_stopen,
    output logic              DE_clr,
    output logic              flush_all,
    output logic              md_busy,
    output logic [CNT_W-1:0]  md_cnt,
    output logic              md_overlap,
    output logic [STAT_W-1:0] stall_cnt
);

    logic flush;
    logic md_hz;
    logic stall;

    // Stall/flush decode: flush wins over stall, and all controls are quiet while in reset
    always_comb begin
        flush     = M_exc_req | M_eret;
        md_hz     = D_is_md & (E_md_start | md_busy);
        stall     = (D_stall_req | md_hz) & ~flush;
        FD_stopen = ~reset & stall;
        DE_clr    = ~reset & (stall | flush);
        flush_all = ~reset & flush;
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (FD_stopen && stall_cnt != '1)
            stall_cnt <= stall_cnt + STAT_W'(1);
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (E_md_start),
        .is_div  (E_md_div),
        .kill    (flush),
        .busy    (md_busy),
        .cnt     (md_cnt),
        .overlap (md_overlap)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed bench with a cycle-level reference model of the stall sequencer
module tb_pipe_stall_ctrl;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 5;
    localparam int SAT    = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic D_stall_req = 1'b0, D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic M_exc_req = 1'b0, M_eret = 1'b0;
    logic FD_stopen, DE_clr, flush_all, md_busy, md_overlap;
    logic [CNT_W-1:0] md_cnt;
    logic [STAT_W-1:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    int m_rem = 0;
    int m_stalls = 0;
    bit m_ovl = 1'b0;

    pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .D_stall_req(D_stall_req), .D_is_md(D_is_md),
        .E_md_start(E_md_start), .E_md_div(E_md_div), .M_exc_req(M_exc_req), .M_eret(M_eret),
        .FD_stopen(FD_stopen), .DE_clr(DE_clr), .flush_all(flush_all), .md_busy(md_busy),
        .md_cnt(md_cnt), .md_overlap(md_overlap), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_flush();
        return M_exc_req || M_eret;
    endfunction

    function automatic bit exp_stall();
        return (D_stall_req || (D_is_md && (E_md_start || m_rem > 0))) && !exp_flush();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining MD cycles as a plain integer, stalls counted up to saturation
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem <= 0;
            m_stalls <= 0;
            m_ovl <= 1'b0;
        end else begin
            if (exp_stall())
                m_stalls <= (m_stalls == SAT) ? SAT : m_stalls + 1;
            if (m_rem > 0) begin
                if (E_md_start)
                    m_ovl <= 1'b1;
                m_rem <= m_rem - 1;
            end else if (E_md_start && !exp_flush()) begin
                m_rem <= E_md_div ? 10 : 5;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("FD_stopen", int'(FD_stopen), int'(exp_stall()));
            check("DE_clr", int'(DE_clr), int'(exp_stall() || exp_flush()));
            check("flush_all", int'(flush_all), int'(exp_flush()));
            check("md_busy", int'(md_busy), int'(m_rem > 0));
            check("md_cnt", int'(md_cnt), m_rem);
            check("md_overlap", int'(md_overlap), int'(m_ovl));
            check("stall_cnt", int'(stall_cnt), m_stalls);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_stall_req = 1'b0; D_is_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;
        M_exc_req = 1'b0; M_eret = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_busy", int'(md_busy), 0);
        check("rst_cnt", int'(md_cnt), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        repeat (2) step();
        reset = 1'b0;
        step();

        // Plain data-hazard stall for three cycles
        for (int i = 0; i < 3; i++) begin
            D_stall_req = 1'b1;
            #1;
            check("t2_fd", int'(FD_stopen), 1);
            check("t2_de", int'(DE_clr), 1);
            step();
        end
        idle_inputs();
        #1;
        check("t2_fd_off", int'(FD_stopen), 0);
        check("t2_de_off", int'(DE_clr), 0);
        check("t2_stall_cnt", int'(stall_cnt), 3);
        step();

        // Mult start with HI/LO reader held in D
        E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
        #1;
        check("t3_fd_start", int'(FD_stopen), 1);
        step();
        E_md_start = 1'b0;
        for (int k = 5; k >= 1; k--) begin
            #1;
            check("t3_busy", int'(md_busy), 1);
            check("t3_cnt", int'(md_cnt), k);
            check("t3_fd", int'(FD_stopen), 1);
            step();
        end
        #1;
        check("t3_busy_end", int'(md_busy), 0);
        check("t3_fd_end", int'(FD_stopen), 0);
        check("t3_stall_cnt", int'(stall_cnt), 9);
        idle_inputs();
        step();

        // Div start killed by an exception in the same cycle
        E_md_start = 1'b1; E_md_div = 1'b1; M_exc_req = 1'b1; D_is_md = 1'b1;
        #1;
        check("t4_flush", int'(flush_all), 1);
        check("t4_de", int'(DE_clr), 1);
        check("t4_fd", int'(FD_stopen), 0);
        step();
        idle_inputs();
        #1;
        check("t4_busy", int'(md_busy), 0);
        step();

        // Div in flight survives an ERET flush, then an illegal overlapping start
        E_md_start = 1'b1; E_md_div = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();
        #1;
        check("t5_cnt7", int'(md_cnt), 7);
        M_eret = 1'b1; D_stall_req = 1'b1; D_is_md = 1'b1;
        #1;
        check("t5_flush", int'(flush_all), 1);
        check("t5_fd", int'(FD_stopen), 0);
        step();
        idle_inputs();
        #1;
        check("t5_cnt6", int'(md_cnt), 6);
        E_md_start = 1'b1; E_md_div = 1'b0;
        step();
        idle_inputs();
        #1;
        check("t6_overlap", int'(md_overlap), 1);
        check("t6_cnt5", int'(md_cnt), 5);
        repeat (5) step();
        #1;
        check("t6_cnt0", int'(md_cnt), 0);
        check("t6_overlap_sticky", int'(md_overlap), 1);
        step();

        // Async reset in the middle of a div
        E_md_start = 1'b1; E_md_div = 1'b1;
        step();
        idle_inputs();
        repeat (4) step();
        #1;
        check("t1_cnt6", int'(md_cnt), 6);
        D_stall_req = 1'b1; M_exc_req = 1'b1;
        reset = 1'b1;
        #1;
        check("t1_busy", int'(md_busy), 0);
        check("t1_cnt", int'(md_cnt), 0);
        check("t1_overlap", int'(md_overlap), 0);
        check("t1_stall_cnt", int'(stall_cnt), 0);
        check("t1_fd", int'(FD_stopen), 0);
        check("t1_de", int'(DE_clr), 0);
        check("t1_flush", int'(flush_all), 0);
        step();
        idle_inputs();
        reset = 1'b0;
        step();

        // Saturation of the stall statistic
        D_stall_req = 1'b1;
        repeat (SAT + 8) step();
        #1;
        check("sat_stall_cnt", int'(stall_cnt), SAT);
        idle_inputs();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
